// File: rtl/s27_bist_ctrl_if.sv
// Pattern/response and control bundle between the s27 BIST controller and its environment.
interface s27_bist_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] num_patterns;
  logic        g17_in;
  logic        g0_out;
  logic        g1_out;
  logic        g2_out;
  logic        g3_out;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic        pass;

  modport master (
    output start, abort, num_patterns, g17_in,
    input  g0_out, g1_out, g2_out, g3_out, busy, done, signature, pass
  );

  modport slave (
    input  start, abort, num_patterns, g17_in,
    output g0_out, g1_out, g2_out, g3_out, busy, done, signature, pass
  );
endinterface

// File: rtl/s27_bist_ctrl.sv
// BIST for the s27 core: LFSR drives G0..G3, SISR compacts G17, FSM runs seed/flush/run/done.
// Optional signature comparator enabled by defining S27_BIST_CMP_EN.
module s27_bist_ctrl #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          FLUSH_CYC  = 4,
  parameter logic [15:0] SIG_POLY   = 16'h1021
`ifdef S27_BIST_CMP_EN
  ,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
`endif
) (
  input  logic            blif_clk_net,
  input  logic            blif_reset_net,
  s27_bist_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  flush_q, flush_d;
  logic [3:0]  pat_q;
  logic        run_q;
  logic        busy_q;
  logic        done_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_SEED;
      end
      S_SEED: begin
        lfsr_d  = LFSR_SEED;
        sig_d   = '0;
        cnt_d   = bus.num_patterns;
        flush_d = 8'(FLUSH_CYC - 1);
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_q == 8'd0) state_d = (cnt_q != 16'd0) ? S_RUN : S_DONE;
        else                 flush_d = flush_q - 8'd1;
      end
      S_RUN: begin
        lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        cnt_d  = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.start) state_d = S_SEED;
      end
      default: state_d = S_IDLE;
    endcase

    // G17 answers the pattern already on the pins, so compaction trails the pattern launch by one edge
    if (run_q && !bus.abort) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SIG_POLY : 16'h0000) ^ {15'b0, bus.g17_in};
    end

    if (bus.abort) state_d = S_IDLE;
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      sig_q   <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      pat_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      pat_q   <= (state_d == S_RUN) ? lfsr_d[3:0] : 4'h0;
      run_q   <= (state_d == S_RUN);
      busy_q  <= (state_d == S_SEED) || (state_d == S_FLUSH) || (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

`ifdef S27_BIST_CMP_EN
  logic pass_q;

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) pass_q <= 1'b0;
    else                pass_q <= (state_d == S_DONE) && (sig_d == GOLDEN_SIG);
  end

  assign bus.pass = pass_q;
`else
  assign bus.pass = 1'b0;
`endif

  assign bus.g0_out    = pat_q[0];
  assign bus.g1_out    = pat_q[1];
  assign bus.g2_out    = pat_q[2];
  assign bus.g3_out    = pat_q[3];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Directed + randomized bench for s27_bist_ctrl against a cycle-timeline reference model.
module tb_s27_bist_ctrl;

  localparam int          F    = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] GOLD = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s27_bist_ctrl_if bus();

  s27_bist_ctrl dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Taps 16,14,13,11 expressed as a mask over the shift-out end
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {^(s & 16'h002D), s[15:1]};
  endfunction

  function automatic logic [15:0] sisr(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {15'b0, b};
  endfunction

  function automatic logic [3:0] pins();
    return {bus.g3_out, bus.g2_out, bus.g1_out, bus.g0_out};
  endfunction

  // mode: 0 = G17 low, 1 = G17 high only on the last sample, 2 = random
  task automatic run_seq(input int n, input int mode, input int abort_at, input bit hold);
    logic [15:0] m_lfsr;
    logic [15:0] m_sig;
    int          total;
    bit          b;
    bit          in_run;
    bit          exp_pass;
    m_lfsr = SEED;
    m_sig  = 16'h0000;
    total  = 1 + F + n;
    bus.num_patterns = n[15:0];
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.g17_in = 1'b0;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    for (int t = 0; t <= total; t++) begin
      if (abort_at >= 0 && t == abort_at + 1) begin
        chk("abort_busy", {31'b0, bus.busy}, 0);
        chk("abort_done", {31'b0, bus.done}, 0);
        chk("abort_pat", {28'b0, pins()}, 0);
        chk("abort_sig", {16'b0, bus.signature}, {16'b0, m_sig});
        bus.abort = 1'b0;
        return;
      end
      in_run = (t >= 1 + F) && (t < total);
      chk("busy", {31'b0, bus.busy}, {31'b0, t < total});
      chk("done", {31'b0, bus.done}, {31'b0, t == total});
      chk("pat", {28'b0, pins()}, in_run ? {28'b0, m_lfsr[3:0]} : 32'd0);
      if (t >= 1) chk("sig", {16'b0, bus.signature}, {16'b0, m_sig});
`ifdef S27_BIST_CMP_EN
      exp_pass = (t == total) && (m_sig == GOLD);
`else
      exp_pass = 1'b0;
`endif
      chk("pass", {31'b0, bus.pass}, {31'b0, exp_pass});
      case (mode)
        0:       b = 1'b0;
        1:       b = (t == total - 1);
        default: b = 1'($urandom_range(0, 1));
      endcase
      bus.g17_in = b;
      if (t == abort_at) begin
        bus.abort = 1'b1;
      end else if (in_run) begin
        m_sig  = sisr(m_sig, b);
        m_lfsr = lfsr_adv(m_lfsr);
      end
      if (t < total) @(negedge clk);
    end
    if (hold) begin
      @(negedge clk);
      chk("restart_busy", {31'b0, bus.busy}, 1);
      chk("restart_done", {31'b0, bus.done}, 0);
      bus.start = 1'b0;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("restart_abort_busy", {31'b0, bus.busy}, 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_patterns = 16'd0;
    bus.g17_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_pat", {28'b0, pins()}, 0);
    chk("rst_sig", {16'b0, bus.signature}, 0);
    chk("rst_pass", {31'b0, bus.pass}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'b0, bus.busy}, 0);

    run_seq(3, 2, -1, 1'b0);
    run_seq(10, 0, -1, 1'b0);
    chk("zero_g17_sig", {16'b0, bus.signature}, 32'h0000);
    run_seq(5, 1, -1, 1'b0);
    chk("last_only_sig", {16'b0, bus.signature}, 32'h0001);
    run_seq(0, 2, -1, 1'b0);
    chk("np0_sig", {16'b0, bus.signature}, 32'h0000);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    run_seq(3, 2, F + 2, 1'b0);
    run_seq(3, 2, -1, 1'b0);
    run_seq(2, 2, -1, 1'b1);
    repeat (3) run_seq(int'($urandom_range(1, 40)), 2, -1, 1'b0);

    // Large count must keep running rather than wrap to an early finish
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.num_patterns = 16'hFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (300) begin
      bus.g17_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("big_busy", {31'b0, bus.busy}, 1);
    chk("big_done", {31'b0, bus.done}, 0);

    // Asynchronous reset while patterns are running
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 0);
    chk("arst_done", {31'b0, bus.done}, 0);
    chk("arst_pat", {28'b0, pins()}, 0);
    chk("arst_sig", {16'b0, bus.signature}, 0);
    chk("arst_pass", {31'b0, bus.pass}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_busy", {31'b0, bus.busy}, 0);
    chk("arst_idle_pat", {28'b0, pins()}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
